jk_sync_down_counter: RTL
=========================

Name: jk_sync_down_counter

Overview:
- Synchronous, parameterised modulo-MOD down counter. It is the count-down counterpart of the team's ripple up counters.
- Every bit toggles on the common clk edge, JK toggle style: bit i toggles when en is high and all lower bits are 0.
- Adds parallel load, a free-run/one-shot mode, a wrap borrow pulse and a done flag, for use as a timer or event down-counter feeding control logic.

Parameters:
- WIDTH, 3, counter width in bits.
- MOD, 8, count modulus; legal range 2 <= MOD <= 2**WIDTH. The counter runs over MOD-1..0.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one decrement per clk edge while high.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded on load.
- mode  input  1  0 = free-run (wrap 0 -> MOD-1), 1 = one-shot (stop at 0).
- out  output  WIDTH  current count.
- zero  output  1  combinational, high when out == 0.
- borrow  output  1  registered one-cycle pulse on wrap.
- done  output  1  registered, high while in DONE state.

Behaviour:
- Reset (rst high, asynchronous, takes effect immediately):
  - out = 0, borrow = 0, done = 0, state = IDLE.
  - While rst is high, clk edges are ignored.
  - Deassertion is synchronous to clk from the block's perspective; the first active edge is the first clk edge with rst low.
- States and transitions:
  - IDLE: out holds.
    - load -> out = clamp(load_val), go COUNT.
    - else en -> apply the decrement rule, go COUNT.
  - COUNT, on en and no load:
    - out > 0 -> out = out - 1.
    - mode=1 and the decrement lands on 0 (out == 1) -> next state DONE.
    - out == 0, mode=0 -> out = MOD-1, borrow = 1 for exactly that following cycle.
    - out == 0, mode=1 (e.g. mode switched mid-count) -> out stays 0, go DONE.
  - DONE: out holds 0 and en is ignored. done = 1 is visible in the same cycle out first shows 0. load -> out = clamp(load_val), done = 0, go COUNT.
- Load rules:
  - Priority: load > en. A load edge never also decrements.
  - clamp(v) = v if v < MOD, else MOD-1.
  - Load of 0 with mode=1 -> out = 0, next state DONE, done = 1, borrow = 0.
- Hold: en = 0 and load = 0 -> out, state and done hold; borrow returns to 0.
- Mode:
  - mode is sampled on each active edge; a change affects only the next decrement.
  - borrow never asserts in mode=1.
- Width/arithmetic:
  - Decrement is modulo MOD, never modulo 2**WIDTH; out never takes a value >= MOD.
  - For MOD = 2**WIDTH, the wrap equals natural all-ones underflow.
  - For MOD < 2**WIDTH, the wrap path forces MOD-1.
- Latency: every change appears one clk edge after the causing input. zero follows out combinationally.

Test Plan:
- Async reset mid-count: out=5 counting; pulse rst between clk edges -> out=0, borrow=0, done=0 before the next edge; edges during rst leave out=0.
- Free-run, WIDTH=3, MOD=8, mode=0, en=1 from reset:
  - out sequence 7,6,5,4,3,2,1,0,7.
  - borrow=1 exactly in each cycle out shows 7 after 0.
  - zero=1 only when out=0.
- Non-power-of-2, MOD=6:
  - load_val=3 then en=1 -> 3,2,1,0,5 with borrow pulse at 5.
  - load_val=7 -> out=5 (clamped).
- One-shot, mode=1:
  - load_val=3, en=1 -> 2,1,0; done=1 with out=0.
  - Further en -> out stays 0, done stays 1.
  - load_val=4 -> out=4, done=0.
- Priority/hold:
  - load=1 and en=1 with out=6, load_val=2 -> out=2 (no decrement).
  - en=0 for 3 cycles -> out holds 2, borrow 0.
- One-shot load 0: mode=1, load_val=0 -> out=0, done=1 next edge, borrow=0; en=1 keeps out=0.

Source files
------------

// File: rtl/jk_sync_down_counter_if.sv
// jk_sync_down_counter_if: control inputs and status outputs of the modulo down counter.
interface jk_sync_down_counter_if #(parameter int WIDTH = 3);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             mode;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             borrow;
    logic             done;
    modport master (output en, load, load_val, mode, input out, zero, borrow, done);
    modport slave (input en, load, load_val, mode, output out, zero, borrow, done);
endinterface

// File: rtl/jk_sync_down_counter.sv
// jk_sync_down_counter: JK-toggle synchronous modulo-MOD down counter with parallel load,
// free-run/one-shot mode, registered wrap borrow pulse and done flag.
module jk_sync_down_counter #(
    parameter int WIDTH = 3,
    parameter int MOD = 8
) (
    input logic clk,
    input logic rst,
    jk_sync_down_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0] MOD_W = (WIDTH + 1)'(MOD);
    localparam bit FULL = MOD == 2 ** WIDTH;
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] toggled;
    logic [WIDTH-1:0] loaded;
    logic at_zero;
    logic borrow;
    logic done;
    // bit i toggles once every lower bit has reached 0
    assign t[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_t
        assign t[i] = t[i-1] & ~cnt[i-1];
    end
    assign toggled = cnt ^ t;
    assign loaded = ({1'b0, bus.load_val} < MOD_W) ? bus.load_val : TOP;
    assign at_zero = cnt == '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            borrow <= 1'b0;
            done   <= 1'b0;
        end else begin
            borrow <= 1'b0;
            if (bus.load) begin
                cnt   <= loaded;
                state <= (bus.mode && loaded == '0) ? DONE : COUNT;
                done  <= bus.mode && loaded == '0;
            end else if (bus.en && state != DONE) begin
                if (at_zero && !bus.mode) begin
                    // all-ones underflow is only the right wrap value for a full-width modulus
                    cnt    <= FULL ? toggled : TOP;
                    borrow <= 1'b1;
                    state  <= COUNT;
                    done   <= 1'b0;
                end else if (bus.mode && (at_zero || cnt == WIDTH'(1))) begin
                    cnt   <= '0;
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    cnt   <= toggled;
                    state <= COUNT;
                    done  <= 1'b0;
                end
            end
        end
    end
    assign bus.out    = cnt;
    assign bus.zero   = at_zero;
    assign bus.borrow = borrow;
    assign bus.done   = done;
endmodule
